fft_load_sequencer: RTL and testbench
=====================================

Name: fft_load_sequencer

Overview:
- Control FSM that sequences the loading of each butterfly operand group into the FFT operand buffer: four 16-bit sample words, then twiddle real, then twiddle imaginary.
- Drives the 3-bit load-count select of the operand-word mux and the buffer write strobe.
- Generates the twiddle ROM address, then hands off to the butterfly unit and waits for completion.
- Iterates over all butterflies of all stages of one frame; sits between the sample input FIFO / twiddle ROM and the butterfly datapath.

Parameters:
- NUM_STAGES, 3, log2 of FFT size (3 = 8-point); butterflies per stage = 2^(NUM_STAGES-1).
- TW_ADDR_W, NUM_STAGES-1, twiddle ROM address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  begin one frame; sampled in IDLE only
- sample_valid  input  1  upstream sample word available
- sample_ready  output  1  sequencer accepts sample word this cycle
- bfly_done  input  1  butterfly unit finished current group (1-cycle pulse)
- bfly_start  output  1  1-cycle pulse, operand group complete
- samples_loaded_count  output  3  operand mux select / buffer write index (0-3 sample, 4 tw real, 5 tw imag)
- buf_wr  output  1  operand buffer write enable
- tw_addr  output  TW_ADDR_W  twiddle ROM address (ROM is combinational)
- stage  output  NUM_STAGES  current stage index
- bfly_idx  output  NUM_STAGES-1  butterfly index within stage
- busy  output  1  high in any state except IDLE
- frame_done  output  1  1-cycle pulse after last butterfly completes

Behaviour:
- Reset (sync, active-high, overrides everything including mid-frame): state=IDLE, samples_loaded_count=0, stage=0, bfly_idx=0; all strobes and busy=0.
- States: IDLE, LOAD_SAMPLES, LOAD_TW_RE, LOAD_TW_IM, WAIT_BFLY, DONE.
- IDLE: start=1 -> LOAD_SAMPLES next cycle, busy=1.
- LOAD_SAMPLES:
  - sample_ready=1 (combinational on state).
  - Each cycle with sample_valid=1: buf_wr=1 at the current count, then count increments.
  - On the 4th accept (count 3) -> LOAD_TW_RE with count=4.
  - sample_valid=0 stalls with no write and no count change.
- LOAD_TW_RE: one cycle, buf_wr=1, count=4, sample_ready=0 -> LOAD_TW_IM, count=5.
- LOAD_TW_IM: one cycle, buf_wr=1, count=5 -> WAIT_BFLY, count=0.
- WAIT_BFLY:
  - bfly_start=1 in the first cycle only.
  - bfly_done is ignored during the bfly_start cycle and honoured from the following cycle.
  - On bfly_done:
    - bfly_idx < 2^(NUM_STAGES-1)-1: bfly_idx++ -> LOAD_SAMPLES.
    - Else, stage < NUM_STAGES-1: bfly_idx=0, stage++ -> LOAD_SAMPLES.
    - Else -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE; stage and bfly_idx clear to 0.
- tw_addr = (bfly_idx & ((1<<stage)-1)) << (NUM_STAGES-1-stage).
  - Combinational from stage and bfly_idx, truncated to TW_ADDR_W.
  - Stable throughout LOAD_TW_RE and LOAD_TW_IM.
- Count never exceeds 5; values 6-7 are unreachable.
- Ignored events:
  - start while busy.
  - sample_valid outside LOAD_SAMPLES (sample_ready=0, no write).
  - bfly_done outside WAIT_BFLY.
- Latency: minimum 7 cycles from group start (first sample accept) to bfly_start, with back-to-back samples.
- Frame total: NUM_STAGES * 2^(NUM_STAGES-1) groups (12 for default).

Decomposition:
- Shared package fft_pkg holds:
  - state enum typedef.
  - localparams CNT_TW_RE=3'd4, CNT_TW_IM=3'd5, SAMPLES_PER_GROUP=4.
  - Function computing tw_addr.
- One natural sub-module: fft_stage_counter.
  - Holds the stage/bfly_idx nested counter with increment input.
  - Outputs last_bfly and last_stage.
  - The FSM and count logic stay in the top.

Test Plan:
- Reset mid-LOAD_SAMPLES (count=2) -> next cycle: IDLE, count=0, buf_wr=0, busy=0; a following start runs a clean frame.
- start, sample_valid held high, bfly_done 3 cycles after each bfly_start:
  - buf_wr asserted at counts 0,1,2,3,4,5.
  - bfly_start 7 cycles after start.
  - frame_done after 12 groups.
  - busy falls the cycle after frame_done.
- sample_valid toggles 1,0,1,0... -> count advances only on valid cycles; no buf_wr on stall cycles; tw states are entered only after the 4th accept.
- Twiddle address sequence, default params:
  - stage 0: tw_addr=0,0,0,0.
  - stage 1: 0,2,0,2.
  - stage 2: 0,1,2,3.
- bfly_done asserted in the same cycle as bfly_start -> ignored, FSM stays in WAIT_BFLY; a bfly_done pulse 1 cycle later advances.
- Spurious events:
  - start pulsed mid-frame -> no effect.
  - bfly_done pulsed during LOAD_SAMPLES -> no effect.
  - sample_valid during WAIT_BFLY -> sample_ready=0, no write.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT operand-load sequencer.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_SAMPLES,
    LOAD_TW_RE,
    LOAD_TW_IM,
    WAIT_BFLY,
    DONE
  } state_t;

  localparam logic [2:0] CNT_TW_RE         = 3'd4;
  localparam logic [2:0] CNT_TW_IM         = 3'd5;
  localparam int         SAMPLES_PER_GROUP = 4;

  // Decimation-in-time twiddle index: the low 'stage' bits of the butterfly
  // index, scaled up to the full-size ROM.
  function automatic int tw_addr_calc(input int stage, input int bfly_idx,
                                      input int num_stages);
    int mask;
    mask = (1 << stage) - 1;
    return (bfly_idx & mask) << (num_stages - 1 - stage);
  endfunction

endpackage

// File: rtl/fft_stage_counter.sv
// Nested stage / butterfly-index counter walking every butterfly of a frame.
module fft_stage_counter #(
  parameter int NUM_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  output logic [NUM_STAGES-1:0] stage,
  output logic [NUM_STAGES-2:0] bfly_idx,
  output logic                  last_bfly,
  output logic                  last_stage
);

  localparam logic [NUM_STAGES-1:0] LAST_STAGE = NUM_STAGES'(NUM_STAGES - 1);

  assign last_bfly  = &bfly_idx;
  assign last_stage = (stage == LAST_STAGE);

  // Increment on the final butterfly of the final stage holds; the FSM clears.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stage    <= '0;
      bfly_idx <= '0;
    end else if (inc) begin
      if (!last_bfly) begin
        bfly_idx <= bfly_idx + 1'b1;
      end else if (!last_stage) begin
        bfly_idx <= '0;
        stage    <= stage + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_load_sequencer.sv
// Sequences sample / twiddle operand loads per butterfly and hands each group to the butterfly unit.
module fft_load_sequencer
  import fft_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int TW_ADDR_W  = NUM_STAGES - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  bfly_done,
  output logic                  bfly_start,
  output logic [2:0]            samples_loaded_count,
  output logic                  buf_wr,
  output logic [TW_ADDR_W-1:0]  tw_addr,
  output logic [NUM_STAGES-1:0] stage,
  output logic [NUM_STAGES-2:0] bfly_idx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [2:0] CNT_LAST_SAMPLE = 3'(SAMPLES_PER_GROUP - 1);

  state_t state;
  logic   last_bfly, last_stage;
  logic   done_ok, frame_end, ctr_inc, ctr_clr;

  // bfly_start marks the first WAIT_BFLY cycle; completion is only taken after it.
  assign done_ok   = (state == WAIT_BFLY) && bfly_done && !bfly_start;
  assign frame_end = last_bfly && last_stage;
  assign ctr_inc   = done_ok && !frame_end;
  assign ctr_clr   = (state == DONE);

  fft_stage_counter #(.NUM_STAGES(NUM_STAGES)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .inc        (ctr_inc),
    .clr        (ctr_clr),
    .stage      (stage),
    .bfly_idx   (bfly_idx),
    .last_bfly  (last_bfly),
    .last_stage (last_stage)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      samples_loaded_count <= '0;
      bfly_start           <= 1'b0;
    end else begin
      bfly_start <= 1'b0;
      case (state)
        IDLE: if (start) state <= LOAD_SAMPLES;
        LOAD_SAMPLES: begin
          if (sample_valid) begin
            if (samples_loaded_count == CNT_LAST_SAMPLE) begin
              state                <= LOAD_TW_RE;
              samples_loaded_count <= CNT_TW_RE;
            end else begin
              samples_loaded_count <= samples_loaded_count + 3'd1;
            end
          end
        end
        LOAD_TW_RE: begin
          state                <= LOAD_TW_IM;
          samples_loaded_count <= CNT_TW_IM;
        end
        LOAD_TW_IM: begin
          state                <= WAIT_BFLY;
          samples_loaded_count <= '0;
          bfly_start           <= 1'b1;
        end
        WAIT_BFLY: if (done_ok) state <= frame_end ? DONE : LOAD_SAMPLES;
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign sample_ready = (state == LOAD_SAMPLES);
  assign buf_wr       = (sample_ready && sample_valid) ||
                        (state == LOAD_TW_RE) || (state == LOAD_TW_IM);
  assign busy         = (state != IDLE);
  assign frame_done   = (state == DONE);
  assign tw_addr      = TW_ADDR_W'(tw_addr_calc(32'(stage), 32'(bfly_idx), NUM_STAGES));

endmodule

// File: tb/tb_fft_load_sequencer.sv
// Directed bench for fft_load_sequencer: full frames under several handshake patterns.
module tb_fft_load_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, sample_valid, bfly_done;
  logic       sample_ready, bfly_start, buf_wr, busy, frame_done;
  logic [2:0] count;
  logic [1:0] tw_addr;
  logic [2:0] stage;
  logic [1:0] bfly_idx;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int t_start = 0;
  int tw_exp [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_load_sequencer #(.NUM_STAGES(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .sample_valid         (sample_valid),
    .sample_ready         (sample_ready),
    .bfly_done            (bfly_done),
    .bfly_start           (bfly_start),
    .samples_loaded_count (count),
    .buf_wr               (buf_wr),
    .tw_addr              (tw_addr),
    .stage                (stage),
    .bfly_idx             (bfly_idx),
    .busy                 (busy),
    .frame_done           (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enters in the first LOAD_SAMPLES cycle of group g, leaves after the edge that consumes bfly_done.
  // mode 0: valid held high; 1: valid toggles plus spurious start/bfly_done; 2: bfly_done with bfly_start.
  task automatic do_group(input int g, input int mode);
    int   acc;
    int   cyc;
    logic v;
    acc = 0;
    cyc = 0;
    while (acc < 4 && cyc < 20) begin
      v            = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
      sample_valid = v;
      if (mode == 1 && cyc == 1) begin
        start     = 1'b1;
        bfly_done = 1'b1;
      end
      #1;
      chk("ld_ready", sample_ready, 1);
      chk("ld_cnt",   count, acc);
      chk("ld_wr",    buf_wr, v);
      chk("ld_stage", stage, g / 4);
      chk("ld_idx",   bfly_idx, g % 4);
      chk("ld_busy",  busy, 1);
      if (v) acc++;
      step();
      start     = 1'b0;
      bfly_done = 1'b0;
      cyc++;
    end
    chk("ld_accepts", acc, 4);
    chk("ld_cycles",  cyc, (mode == 1) ? 7 : 4);
    sample_valid = 1'b1;
    #1;
    chk("twre_cnt",   count, 4);
    chk("twre_wr",    buf_wr, 1);
    chk("twre_ready", sample_ready, 0);
    chk("twre_addr",  tw_addr, tw_exp[g]);
    step();
    #1;
    chk("twim_cnt",   count, 5);
    chk("twim_wr",    buf_wr, 1);
    chk("twim_addr",  tw_addr, tw_exp[g]);
    step();
    #1;
    chk("wait_start", bfly_start, 1);
    chk("wait_cnt",   count, 0);
    chk("wait_wr",    buf_wr, 0);
    chk("wait_ready", sample_ready, 0);
    if (g == 0 && mode == 0) chk("latency", cyc_cnt - t_start, 7);
    if (mode == 2) begin
      bfly_done = 1'b1;
      step();
      #1;
      chk("early_start", bfly_start, 0);
      chk("early_ready", sample_ready, 0);
      chk("early_fdone", frame_done, 0);
      chk("early_busy",  busy, 1);
      step();
      bfly_done = 1'b0;
    end else begin
      step();
      #1;
      chk("wait_start_fall", bfly_start, 0);
      step();
      step();
      bfly_done = 1'b1;
      #1;
      chk("wait_hold_ready", sample_ready, 0);
      step();
      bfly_done = 1'b0;
    end
  endtask

  task automatic run_frame(input int mode);
    sample_valid = 1'b0;
    start        = 1'b1;
    t_start      = cyc_cnt;
    #1;
    chk("idle_busy", busy, 0);
    step();
    start = 1'b0;
    for (int g = 0; g < 12; g++) do_group(g, mode);
    #1;
    chk("fdone",       frame_done, 1);
    chk("fdone_busy",  busy, 1);
    chk("fdone_ready", sample_ready, 0);
    step();
    #1;
    chk("post_fdone",  frame_done, 0);
    chk("post_busy",   busy, 0);
    chk("post_stage",  stage, 0);
    chk("post_idx",    bfly_idx, 0);
    chk("post_wr",     buf_wr, 0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    sample_valid = 1'b0;
    bfly_done    = 1'b0;
    step();
    step();
    #1;
    chk("rst_busy",  busy, 0);
    chk("rst_cnt",   count, 0);
    chk("rst_wr",    buf_wr, 0);
    chk("rst_stage", stage, 0);
    chk("rst_idx",   bfly_idx, 0);
    chk("rst_bs",    bfly_start, 0);
    chk("rst_fd",    frame_done, 0);
    rst = 1'b0;
    step();

    // Reset in the middle of a frame (stage 1, butterfly 1, two samples in).
    start   = 1'b1;
    t_start = cyc_cnt;
    step();
    start = 1'b0;
    for (int g = 0; g < 5; g++) do_group(g, 0);
    sample_valid = 1'b1;
    step();
    step();
    #1;
    chk("mid_cnt",   count, 2);
    chk("mid_stage", stage, 1);
    chk("mid_idx",   bfly_idx, 1);
    rst = 1'b1;
    step();
    #1;
    chk("mrst_busy",  busy, 0);
    chk("mrst_cnt",   count, 0);
    chk("mrst_wr",    buf_wr, 0);
    chk("mrst_ready", sample_ready, 0);
    chk("mrst_stage", stage, 0);
    chk("mrst_idx",   bfly_idx, 0);
    rst          = 1'b0;
    sample_valid = 1'b0;
    step();

    run_frame(0);
    step();
    run_frame(1);
    step();
    run_frame(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
